// File: rtl/reg_op_arbiter.sv
// ---------------------------------------------------------------------------
// reg_op_arbiter
// Shares a bank of funsel-controlled registers (clear/load/dec/inc) among
// several requesters. One operation is accepted at a time using round-robin
// order. The selected register is then driven with one-cycle enable pulses,
// and each pulse is followed by a one-cycle gap.
//
// Ports
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   req_valid    : per-requester operation request
//   req_funsel   : per-requester op code (00 clr, 01 load, 10 dec, 11 inc)
//   req_sel      : per-requester target register index
//   req_data     : per-requester load value
//   req_count    : per-requester repeat count for dec/inc (0 means 1)
//   req_ready    : combinational one-hot acceptance pulse
//   req_done     : registered one-hot completion pulse
//   reg_enable   : one-hot register enable to the bank
//   reg_funsel   : shared funsel to the bank
//   reg_load     : shared load data to the bank
//   busy         : high whenever an operation is in progress
//   grant_id     : index of the last accepted requester
// ---------------------------------------------------------------------------
module reg_op_arbiter #(
    parameter int NREQ = 4,
    parameter int NREG = 4,
    parameter int N    = 8,
    parameter int CW   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [2*NREQ-1:0]  req_funsel,
    input  logic [2*NREQ-1:0]  req_sel,
    input  logic [N*NREQ-1:0]  req_data,
    input  logic [CW*NREQ-1:0] req_count,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    req_done,
    output logic [NREG-1:0]    reg_enable,
    output logic [1:0]         reg_funsel,
    output logic [N-1:0]       reg_load,
    output logic               busy,
    output logic [1:0]         grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    localparam logic [CW-1:0] ONE_STEP = {{(CW-1){1'b0}}, 1'b1};

    // Convert a 2-bit index into a 4-bit one-hot vector.
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Clear and load take one step. Dec and inc repeat count times, and a
    // count of zero still takes one step.
    function automatic logic [CW-1:0] step_count(input logic [1:0] f, input logic [CW-1:0] c);
        logic [CW-1:0] s;
        if (!f[1]) begin
            s = ONE_STEP;
        end else if (c == '0) begin
            s = ONE_STEP;
        end else begin
            s = c;
        end
        return s;
    endfunction

    state_e        state_q, state_d;
    logic [1:0]    rr_ptr_q, rr_ptr_d;
    logic [1:0]    grant_id_q, grant_id_d;
    logic [1:0]    op_funsel_q, op_funsel_d;
    logic [1:0]    op_sel_q, op_sel_d;
    logic [N-1:0]  op_data_q, op_data_d;
    logic [CW-1:0] remain_q, remain_d;

    logic [NREG-1:0] reg_enable_q, reg_enable_d;
    logic [1:0]      reg_funsel_q, reg_funsel_d;
    logic [N-1:0]    reg_load_q, reg_load_d;
    logic [NREQ-1:0] req_done_q, req_done_d;
    logic            busy_q, busy_d;

    logic            gnt_found_s;
    logic [1:0]      gnt_idx_s;
    logic [NREQ-1:0] req_ready_s;

    // Round-robin search: pick the first valid requester, starting at rr_ptr.
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_idx_s   = rr_ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_found_s && req_valid[rr_ptr_q + 2'(k)]) begin
                gnt_found_s = 1'b1;
                gnt_idx_s   = rr_ptr_q + 2'(k);
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
    end

    // Next-state logic: capture the operation on grant and count down the steps.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        op_funsel_d = op_funsel_q;
        op_sel_d    = op_sel_q;
        op_data_d   = op_data_q;
        remain_d    = remain_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_found_s) begin
                    state_d     = ST_PULSE;
                    grant_id_d  = gnt_idx_s;
                    op_funsel_d = req_funsel[2*gnt_idx_s +: 2];
                    op_sel_d    = req_sel[2*gnt_idx_s +: 2];
                    op_data_d   = req_data[N*gnt_idx_s +: N];
                    remain_d    = step_count(req_funsel[2*gnt_idx_s +: 2],
                                             req_count[CW*gnt_idx_s +: CW]);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PULSE: begin
                remain_d = remain_q - ONE_STEP;
                state_d  = ST_GAP;
            end
            ST_GAP: begin
                if (remain_q != '0) begin
                    state_d = ST_PULSE;
                end else begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = grant_id_q + 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic. Bank drive values are computed from the next state so that
    // the registered outputs line up with the state they belong to.
    always_comb begin
        reg_enable_d = '0;
        reg_funsel_d = 2'b00;
        reg_load_d   = '0;
        req_done_d   = '0;
        req_ready_s  = '0;
        busy_d       = (state_d != ST_IDLE);
        if (state_d == ST_PULSE) begin
            reg_enable_d = onehot4(op_sel_d);
            reg_funsel_d = op_funsel_d;
            reg_load_d   = op_data_d;
        end else begin
            reg_enable_d = '0;
        end
        if ((state_q == ST_GAP) && (state_d == ST_IDLE)) begin
            req_done_d = onehot4(grant_id_q);
        end else begin
            req_done_d = '0;
        end
        if ((state_q == ST_IDLE) && gnt_found_s) begin
            req_ready_s = onehot4(gnt_idx_s);
        end else begin
            req_ready_s = '0;
        end
    end

    // State and captured-operation registers. Reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= 2'd0;
            grant_id_q  <= 2'd0;
            op_funsel_q <= 2'b00;
            op_sel_q    <= 2'd0;
            op_data_q   <= '0;
            remain_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            op_funsel_q <= op_funsel_d;
            op_sel_q    <= op_sel_d;
            op_data_q   <= op_data_d;
            remain_q    <= remain_d;
        end
    end

    // Registered bank drive, completion pulse and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_enable_q <= '0;
            reg_funsel_q <= 2'b00;
            reg_load_q   <= '0;
            req_done_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            reg_enable_q <= reg_enable_d;
            reg_funsel_q <= reg_funsel_d;
            reg_load_q   <= reg_load_d;
            req_done_q   <= req_done_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready  = req_ready_s;
    assign req_done   = req_done_q;
    assign reg_enable = reg_enable_q;
    assign reg_funsel = reg_funsel_q;
    assign reg_load   = reg_load_q;
    assign busy       = busy_q;
    assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_reg_op_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_op_arbiter
// Directed bench for reg_op_arbiter. Inputs change 2 ns after the falling
// edge. Outputs are sampled 1 ns after that, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_reg_op_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [7:0]  req_funsel;
    logic [7:0]  req_sel;
    logic [31:0] req_data;
    logic [15:0] req_count;
    logic [3:0]  req_ready;
    logic [3:0]  req_done;
    logic [3:0]  reg_enable;
    logic [1:0]  reg_funsel;
    logic [7:0]  reg_load;
    logic        busy;
    logic [1:0]  grant_id;

    int compared   = 0;
    int mismatched = 0;
    int inc_pulses = 0;

    reg_op_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_funsel (req_funsel),
        .req_sel    (req_sel),
        .req_data   (req_data),
        .req_count  (req_count),
        .req_ready  (req_ready),
        .req_done   (req_done),
        .reg_enable (reg_enable),
        .reg_funsel (reg_funsel),
        .reg_load   (reg_load),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic [1:0] f, input logic [1:0] s,
                           input logic [7:0] d, input logic [3:0] c);
        req_funsel[2*i +: 2] = f;
        req_sel[2*i +: 2]    = s;
        req_data[8*i +: 8]   = d;
        req_count[4*i +: 4]  = c;
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 4'h0;
        req_funsel = 8'h00;
        req_sel    = 8'h00;
        req_data   = 32'h0;
        req_count  = 16'h0;

        // Reset state
        #3;
        chk("rst_busy",   8'(busy),       8'h00);
        chk("rst_enable", 8'(reg_enable), 8'h00);
        chk("rst_done",   8'(req_done),   8'h00);
        chk("rst_grant",  8'(grant_id),   8'h00);
        chk("rst_load",   reg_load,       8'h00);
        cyc();
        cyc();
        rst_n = 1'b1;

        // Single load: req 2, sel 3, data A5
        cyc();
        set_req(2, 2'b01, 2'd3, 8'hA5, 4'd0);
        req_valid = 4'b0100;
        #1;
        chk("t1_ready0", 8'(req_ready), 8'h04);
        chk("t1_busy0",  8'(busy),      8'h00);
        cyc();
        req_valid = 4'b0000;
        #1;
        chk("t1_en1",     8'(reg_enable), 8'h08);
        chk("t1_funsel1", 8'(reg_funsel), 8'h01);
        chk("t1_load1",   reg_load,       8'hA5);
        chk("t1_busy1",   8'(busy),       8'h01);
        chk("t1_grant1",  8'(grant_id),   8'h02);
        chk("t1_ready1",  8'(req_ready),  8'h00);
        cyc();
        #1;
        chk("t1_en2",   8'(reg_enable), 8'h00);
        chk("t1_busy2", 8'(busy),       8'h01);
        chk("t1_done2", 8'(req_done),   8'h00);
        cyc();
        #1;
        chk("t1_done3", 8'(req_done),   8'h04);
        chk("t1_busy3", 8'(busy),       8'h00);
        chk("t1_en3",   8'(reg_enable), 8'h00);
        cyc();
        #1;
        chk("t1_done4", 8'(req_done), 8'h00);

        // Burst increment: req 0, sel 1, count 3. Other requests arrive while busy.
        cyc();
        set_req(0, 2'b11, 2'd1, 8'h3C, 4'd3);
        req_valid = 4'b0001;
        #1;
        chk("t2_ready0", 8'(req_ready), 8'h01);
        for (int c = 1; c <= 6; c++) begin
            cyc();
            if (c == 1) begin
                req_valid = 4'b0000;
                set_req(0, 2'b00, 2'd2, 8'hFF, 4'd9);
            end else if (c == 2) begin
                set_req(3, 2'b00, 2'd2, 8'h11, 4'd0);
                set_req(1, 2'b01, 2'd0, 8'h77, 4'd0);
                req_valid = 4'b1010;
            end else if (c == 4) begin
                set_req(1, 2'b10, 2'd3, 8'h66, 4'd7);
                req_valid = 4'b1000;
            end
            #1;
            chk("t2_ready_busy", 8'(req_ready), 8'h00);
            if ((c % 2) == 1) begin
                chk("t2_en_pulse", 8'(reg_enable), 8'h02);
                chk("t2_funsel",   8'(reg_funsel), 8'h03);
                chk("t2_load",     reg_load,       8'h3C);
                if (reg_enable == 4'b0010 && reg_funsel == 2'b11) inc_pulses++;
            end else begin
                chk("t2_en_gap", 8'(reg_enable), 8'h00);
            end
        end
        cyc();
        #1;
        chk("t2_done7",   8'(req_done),  8'h01);
        chk("t2_ready7",  8'(req_ready), 8'h08);
        chk("t2_reg_inc", 8'(inc_pulses), 8'h03);
        cyc();
        req_valid = 4'b0000;
        #1;
        chk("t2_en8",     8'(reg_enable), 8'h04);
        chk("t2_funsel8", 8'(reg_funsel), 8'h00);
        chk("t2_grant8",  8'(grant_id),   8'h03);
        cyc();
        #1;
        chk("t2_en9", 8'(reg_enable), 8'h00);
        cyc();
        #1;
        chk("t2_done10", 8'(req_done), 8'h08);

        // Decrement with count 0: one pulse only
        cyc();
        set_req(1, 2'b10, 2'd0, 8'h00, 4'd0);
        req_valid = 4'b0010;
        #1;
        chk("t3_ready0", 8'(req_ready), 8'h02);
        cyc();
        req_valid = 4'b0000;
        #1;
        chk("t3_en1",     8'(reg_enable), 8'h01);
        chk("t3_funsel1", 8'(reg_funsel), 8'h02);
        cyc();
        #1;
        chk("t3_en2", 8'(reg_enable), 8'h00);
        cyc();
        #1;
        chk("t3_done3", 8'(req_done),   8'h02);
        chk("t3_en3",   8'(reg_enable), 8'h00);
        chk("t3_busy3", 8'(busy),       8'h00);
        cyc();
        #1;
        chk("t3_en4",   8'(reg_enable), 8'h00);
        chk("t3_done4", 8'(req_done),   8'h00);

        // Async reset during the second pulse of a count-5 increment
        cyc();
        set_req(2, 2'b11, 2'd1, 8'h5A, 4'd5);
        req_valid = 4'b0100;
        #1;
        chk("t4_ready0", 8'(req_ready), 8'h04);
        cyc();
        req_valid = 4'b0000;
        #1;
        chk("t4_en1", 8'(reg_enable), 8'h02);
        cyc();
        #1;
        chk("t4_en2", 8'(reg_enable), 8'h00);
        cyc();
        #1;
        chk("t4_en3", 8'(reg_enable), 8'h02);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_en",     8'(reg_enable), 8'h00);
        chk("t4_rst_busy",   8'(busy),       8'h00);
        chk("t4_rst_grant",  8'(grant_id),   8'h00);
        chk("t4_rst_funsel", 8'(reg_funsel), 8'h00);
        cyc();
        #1;
        chk("t4_hold_en",   8'(reg_enable), 8'h00);
        chk("t4_hold_done", 8'(req_done),   8'h00);

        // Round robin: all four valid with clear ops. sel of requester i is 3-i.
        cyc();
        for (int i = 0; i < 4; i++) set_req(i, 2'b00, 2'(3 - i), 8'(i), 4'd0);
        req_valid = 4'b1111;
        rst_n = 1'b1;
        #1;
        for (int g = 0; g < 5; g++) begin
            if (g > 0) begin
                cyc();
                #1;
                chk("rr_done", 8'(req_done), 8'h01 << ((g - 1) % 4));
            end
            chk("rr_ready", 8'(req_ready), 8'h01 << (g % 4));
            cyc();
            if (g == 4) req_valid = 4'b0000;
            #1;
            chk("rr_ready_p", 8'(req_ready), 8'h00);
            chk("rr_en",      8'(reg_enable), 8'h01 << (3 - (g % 4)));
            chk("rr_grant",   8'(grant_id),   8'(g % 4));
            cyc();
            #1;
            chk("rr_ready_g", 8'(req_ready),  8'h00);
            chk("rr_en_gap",  8'(reg_enable), 8'h00);
        end
        cyc();
        #1;
        chk("rr_done_last", 8'(req_done), 8'h01);
        chk("rr_busy_last", 8'(busy),     8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
